// File: rtl/cpu_controller_if.sv
// RAM-side bus of the cpu_controller: the controller is master, the 32x8 RAM is slave.
interface cpu_controller_if;
  logic       writeEn;
  logic [4:0] address;
  logic [7:0] dataIn;
  logic [7:0] ramOut;

  modport master (output writeEn, address, dataIn, input ramOut);
  modport slave  (input writeEn, address, dataIn, output ramOut);
endinterface

// File: rtl/cpu_controller.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator processor.
// Holds PC, IR, ACC and flags; RAM outputs are Moore-decoded from state.
module cpu_controller (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run,
  cpu_controller_if.master        ram,
  output logic [4:0]              pc,
  output logic [7:0]              acc,
  output logic                    zero,
  output logic                    carry,
  output logic                    halted
);

  typedef enum logic [2:0] {
    FETCH, DECODE, READ, WB, STORE, HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_LDA = 3'b000, OP_STA = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011,
    OP_JMP = 3'b100, OP_JZ  = 3'b101, OP_JC  = 3'b110, OP_HLT = 3'b111
  } opcode_t;

  state_t     state, next_state;
  logic [7:0] ir;
  opcode_t    fetched_op, exec_op;
  logic       take_jump;
  logic [8:0] sum9, diff9;

  // DECODE acts on the word arriving from RAM, since ir is only loaded at its end.
  assign fetched_op = opcode_t'(ram.ramOut[7:5]);
  assign exec_op    = opcode_t'(ir[7:5]);
  assign sum9       = {1'b0, acc} + {1'b0, ram.ramOut};
  assign diff9      = {1'b0, acc} - {1'b0, ram.ramOut};

  always_comb begin
    take_jump = 1'b0;
    case (fetched_op)
      OP_JMP:  take_jump = 1'b1;
      OP_JZ:   take_jump = zero;
      OP_JC:   take_jump = carry;
      default: take_jump = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    ram.writeEn = 1'b0;
    ram.address = pc;
    ram.dataIn  = acc;
    halted      = 1'b0;
    case (state)
      FETCH:  if (run) next_state = DECODE;
      DECODE: begin
        case (fetched_op)
          OP_LDA, OP_ADD, OP_SUB: next_state = READ;
          OP_STA:                 next_state = STORE;
          OP_HLT:                 next_state = HALT;
          default:                next_state = FETCH;
        endcase
      end
      READ: begin
        ram.address = ir[4:0];
        next_state  = WB;
      end
      WB:    next_state = FETCH;
      STORE: begin
        ram.address = ir[4:0];
        ram.writeEn = 1'b1;
        next_state  = FETCH;
      end
      HALT: begin
        halted     = 1'b1;
        next_state = HALT;
      end
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc    <= '0;
      ir    <= '0;
      acc   <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
    end else begin
      case (state)
        DECODE: begin
          ir <= ram.ramOut;
          pc <= take_jump ? ram.ramOut[4:0] : pc + 5'd1;
        end
        WB: begin
          case (exec_op)
            OP_ADD: begin
              acc   <= sum9[7:0];
              carry <= sum9[8];
              zero  <= (sum9[7:0] == 8'd0);
            end
            OP_SUB: begin
              acc   <= diff9[7:0];
              carry <= diff9[8];
              zero  <= (diff9[7:0] == 8'd0);
            end
            default: begin
              acc   <= ram.ramOut;
              carry <= 1'b0;
              zero  <= (ram.ramOut == 8'd0);
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller with a behavioural 32x8 synchronous-read RAM.
module tb_cpu_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic [4:0] pc;
  logic [7:0] acc;
  logic       zero, carry, halted;

  cpu_controller_if bus ();

  cpu_controller dut (
    .clock  (clock),
    .reset  (reset),
    .run    (run),
    .ram    (bus),
    .pc     (pc),
    .acc    (acc),
    .zero   (zero),
    .carry  (carry),
    .halted (halted)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [32];

  always @(posedge clock) begin
    if (bus.writeEn) mem[bus.address] <= bus.dataIn;
    bus.ramOut <= mem[bus.address];
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  // Hold reset, clear RAM, then release at a falling edge with run low.
  task automatic restart;
    run   = 1'b0;
    reset = 1'b0;
    cycles(2);
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic release_reset;
    reset = 1'b1;
    cycles(1);
  endtask

  initial begin
    restart();
    for (int unsigned i = 0; i < 10; i++) begin
      check("rst_pc",     {27'd0, pc},        32'd0);
      check("rst_we",     {31'd0, bus.writeEn}, 32'd0);
      check("rst_addr",   {27'd0, bus.address}, 32'd0);
      check("rst_din",    {24'd0, bus.dataIn},  32'd0);
      check("rst_flags",  {29'd0, halted, zero, carry}, 32'd0);
      check("rst_acc",    {24'd0, acc},       32'd0);
      cycles(1);
    end
    release_reset();
    for (int unsigned i = 0; i < 10; i++) begin
      check("idle_pc", {27'd0, pc}, 32'd0);
      check("idle_we", {31'd0, bus.writeEn}, 32'd0);
      cycles(1);
    end

    // LDA 30, ADD 31, STA 29, HLT
    restart();
    mem[0] = 8'h1E; mem[1] = 8'h5F; mem[2] = 8'h3D; mem[3] = 8'hE0;
    mem[30] = 8'h7F; mem[31] = 8'h01;
    release_reset();
    run = 1'b1;
    cycles(12);
    check("p1_not_halted_12", {31'd0, halted}, 32'd0);
    cycles(1);
    check("p1_halted_13", {31'd0, halted}, 32'd1);
    check("p1_acc",   {24'd0, acc}, 32'h80);
    check("p1_carry", {31'd0, carry}, 32'd0);
    check("p1_zero",  {31'd0, zero}, 32'd0);
    check("p1_m29",   {24'd0, mem[29]}, 32'h80);
    check("p1_pc",    {27'd0, pc}, 32'd4);
    cycles(5);
    check("p1_sticky", {31'd0, halted}, 32'd1);
    check("p1_halt_we", {31'd0, bus.writeEn}, 32'd0);
    check("p1_halt_addr", {27'd0, bus.address}, 32'd4);

    // LDA 0xFF, ADD 0x01, JZ 10
    restart();
    mem[0] = 8'h1E; mem[1] = 8'h5F; mem[2] = 8'hAA; mem[10] = 8'hE0;
    mem[30] = 8'hFF; mem[31] = 8'h01;
    release_reset();
    run = 1'b1;
    cycles(10);
    run = 1'b0;
    check("p2_acc",   {24'd0, acc}, 32'h00);
    check("p2_zero",  {31'd0, zero}, 32'd1);
    check("p2_carry", {31'd0, carry}, 32'd1);
    check("p2_pc",    {27'd0, pc}, 32'd10);
    cycles(4);
    check("p2_parked_pc", {27'd0, pc}, 32'd10);
    check("p2_parked_halt", {31'd0, halted}, 32'd0);

    // LDA 0x00, SUB 0x01, JC 12 (taken) then JZ 12 (not taken)
    for (int unsigned k = 0; k < 2; k++) begin
      restart();
      mem[0] = 8'h1E; mem[1] = 8'h7F; mem[2] = (k == 0) ? 8'hCC : 8'hAC;
      mem[30] = 8'h00; mem[31] = 8'h01;
      release_reset();
      run = 1'b1;
      cycles(10);
      run = 1'b0;
      check("p3_acc",   {24'd0, acc}, 32'hFF);
      check("p3_carry", {31'd0, carry}, 32'd1);
      check("p3_zero",  {31'd0, zero}, 32'd0);
      check("p3_pc",    {27'd0, pc}, (k == 0) ? 32'd12 : 32'd3);
    end

    // JMP 31; M31 = LDA 0 -> pc wraps to 0, acc = M0
    restart();
    mem[0] = 8'h9F; mem[31] = 8'h00;
    release_reset();
    run = 1'b1;
    cycles(2);
    check("p4_pc_jmp", {27'd0, pc}, 32'd31);
    cycles(2);
    check("p4_pc_wrap", {27'd0, pc}, 32'd0);
    cycles(2);
    run = 1'b0;
    check("p4_acc",   {24'd0, acc}, 32'h9F);
    check("p4_flags", {30'd0, zero, carry}, 32'd0);

    // LDA 30, STA 29; reset asserted while in STORE
    restart();
    mem[0] = 8'h1E; mem[1] = 8'h3D; mem[30] = 8'h55;
    release_reset();
    run = 1'b1;
    cycles(6);
    check("p5_store_we",   {31'd0, bus.writeEn}, 32'd1);
    check("p5_store_addr", {27'd0, bus.address}, 32'd29);
    check("p5_store_din",  {24'd0, bus.dataIn},  32'h55);
    #1 reset = 1'b0;
    #1;
    check("p5_async_we",   {31'd0, bus.writeEn}, 32'd0);
    check("p5_async_addr", {27'd0, bus.address}, 32'd0);
    check("p5_async_acc",  {24'd0, acc}, 32'd0);
    run = 1'b0;
    cycles(2);
    release_reset();
    check("p5_pc_after", {27'd0, pc}, 32'd0);
    check("p5_acc_after", {24'd0, acc}, 32'd0);
    run = 1'b1;
    cycles(4);
    run = 1'b0;
    check("p5_restart_acc", {24'd0, acc}, 32'h55);
    check("p5_restart_pc",  {27'd0, pc}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Fetch/decode/execute sequencer for the simple 8-bit processor. It drives the 32x8 single-port RAM as the processor's only memory, and holds PC, instruction register, accumulator and flags. Each RAM word is either an instruction (opcode[7:5], operand address[4:0]) or data. The block sits between the top level (run/status) and the RAM.

## Interface
- No parameters (data width 8, address width 5, fixed).
- clock  in  1  rising-edge system clock
- reset  in  1  asynchronous, active-low; resets all state at once, independent of the clock
- run  in  1  start/continue gate; sampled only in FETCH
- ramOut  in  8  RAM read data; valid the cycle after an address is presented with writeEn=0
- writeEn  out  1  RAM write enable
- address  out  5  RAM address
- dataIn  out  8  RAM write data; always equals acc
- pc  out  5  program counter
- acc  out  8  accumulator
- zero  out  1  zero flag
- carry  out  1  carry/borrow flag
- halted  out  1  high in HALT state

## Operation
- ISA, opcode = ir[7:5], operand a = ir[4:0]:
  - 000 LDA: acc ← M[a]
  - 001 STA: M[a] ← acc
  - 010 ADD: {carry, acc} ← acc + M[a]
  - 011 SUB: acc ← acc − M[a]; carry = borrow
  - 100 JMP: pc ← a
  - 101 JZ: pc ← a if zero
  - 110 JC: pc ← a if carry
  - 111 HLT
- States: FETCH, DECODE, READ, WB, STORE, HALT. Outputs are decoded only from registered state (Moore).
- FETCH: address=pc, writeEn=0. run=1 → DECODE; run=0 → stay in FETCH.
- DECODE: ir ← ramOut; pc ← pc+1, or pc ← a for taken JMP/JZ/JC. Next state:
  - LDA/ADD/SUB → READ
  - STA → STORE
  - JMP/JZ/JC → FETCH
  - HLT → HALT
- READ: address=a, writeEn=0 → WB.
- WB: acc updated per opcode; zero ← (new acc==0) → FETCH.
  - LDA clears carry.
  - ADD: carry = bit 8 of the 9-bit sum.
  - SUB: carry = 1 when M[a] > acc (unsigned).
- STORE: address=a, writeEn=1, dataIn=acc → FETCH. Flags unchanged.
- HALT: sticky until reset; writeEn=0, address=pc, halted=1.
- address=pc in every state except READ/STORE. writeEn=1 only in STORE.
- Arithmetic is unsigned 8-bit and wraps modulo 256. PC increments modulo 32 (31 → 0).
- Flags are changed only by WB. Jumps, STA and HLT leave them untouched.

## Timing
- Reset values: state=FETCH, pc=0, ir=0, acc=0, zero=0, carry=0, writeEn=0, address=0, dataIn=0, halted=0.
- Cycles per instruction, counted from entering FETCH with run=1:
  - LDA/ADD/SUB: 4
  - STA: 3
  - JMP/JZ/JC (taken or not): 2
  - HLT: 2, then halted=1 from the following cycle
- Read latency: address presented in cycle N, ramOut consumed in cycle N+1 (DECODE after FETCH, WB after READ).
- Write: RAM captures at the clock edge ending STORE.
- run is ignored outside FETCH, so an instruction in flight always completes. Deasserting run parks the block in FETCH with pc stable.
- Reset mid-instruction, including during STORE: writeEn drops to 0 immediately (asynchronous); a pending write is not guaranteed; execution restarts from pc=0.

## Test plan
- Reset with run=0 for 10 cycles → all outputs at reset values, writeEn never 1, pc stays 0.
- Program M0=0x1E (LDA 30), M1=0x5F (ADD 31), M2=0x3D (STA 29), M3=0xE0 (HLT); M30=0x7F, M31=0x01; run=1 → acc=0x80, carry=0, zero=0, M29=0x80, halted=1 exactly 13 cycles after run.
- Program LDA 0xFF, ADD 0x01, JZ 10 → acc=0x00, zero=1, carry=1, pc=10 after the JZ's DECODE.
- Program LDA 0x00, SUB 0x01, JC 12 → acc=0xFF, carry=1, zero=0, pc=12; repeat with JZ → not taken, pc increments.
- Program JMP 31 with M31=LDA 0 → pc=0 after the fetch at 31 (wrap); acc=M0.
- Reset asserted mid-STORE → writeEn=0 the same instant; after release pc=0, state=FETCH, acc=0.
